// File: rtl/memory_map.sv
// memory_map: Hack-style data memory map with RAM, a screen shadow with a
// write FIFO towards the display, and a keyboard register.
//   0x0000-0x3FFF RAM, 0x4000-0x5FFF SCREEN, 0x6000 KBD, rest unmapped (reads 0).
// Optional build macro KBD_SYNC_EN: puts a two-flop synchronizer in front of
// the keyboard register. Without it kbd_in is captured directly.
// Handshake: the FIFO head is offered with scr_valid; it leaves the FIFO on a
// rising clk edge where scr_valid and scr_ready are both 1. The head stays
// stable while scr_valid=1 and scr_ready=0.
module memory_map #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  output logic        stall,
  input  logic [15:0] kbd_in,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_valid,
  input  logic        scr_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // Storage arrays: never reset, contents undefined until written.
  logic [15:0] ram_mem    [16384];
  logic [15:0] shadow_mem [8192];
  logic [28:0] fifo_mem   [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   kbd_q, kbd_d;

  logic ram_sel, scr_sel, kbd_sel;
  logic fifo_full, push, pop;

  // Address decode of the CPU data address.
  always_comb begin
    ram_sel = 1'b0;
    scr_sel = 1'b0;
    kbd_sel = 1'b0;
    if (addressM[14] == 1'b0) begin
      ram_sel = 1'b1;
    end else if (addressM[13] == 1'b0) begin
      scr_sel = 1'b1;
    end else if (addressM == 15'h6000) begin
      kbd_sel = 1'b1;
    end
  end

  // Combinational read mux back to the CPU; unmapped space reads as zero.
  always_comb begin
    inM = 16'h0000;
    if (ram_sel) begin
      inM = ram_mem[addressM[13:0]];
    end else if (scr_sel) begin
      inM = shadow_mem[addressM[12:0]];
    end else if (kbd_sel) begin
      inM = kbd_q;
    end
  end

  // FIFO control: full is judged on start-of-cycle occupancy, so a pop in
  // the same cycle does not release a stalled write until the next cycle.
  always_comb begin
    fifo_full = (count_q == FULL_CNT);
    scr_valid = (count_q != '0);
    stall     = writeM & scr_sel & fifo_full;
    push      = writeM & scr_sel & ~fifo_full;
    pop       = scr_valid & scr_ready;
    wr_ptr_d  = wr_ptr_q + {{(AW-1){1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{(AW-1){1'b0}}, pop};
    count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // Head of the FIFO is presented straight from storage (no bypass path).
  always_comb begin
    scr_addr = fifo_mem[rd_ptr_q][28:16];
    scr_data = fifo_mem[rd_ptr_q][15:0];
  end

  // FIFO pointer and occupancy flops; reset empties the FIFO asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // RAM, screen shadow and FIFO storage writes (no reset on purpose).
  always_ff @(posedge clk) begin
    if (writeM && ram_sel) begin
      ram_mem[addressM[13:0]] <= outM;
    end
    if (push) begin
      shadow_mem[addressM[12:0]] <= outM;
      fifo_mem[wr_ptr_q]         <= {addressM[12:0], outM};
    end
  end

`ifdef KBD_SYNC_EN
  logic [15:0] sync1_q, sync1_d;
  logic [15:0] sync2_q, sync2_d;

  // Two-flop synchronizer in front of the keyboard register.
  always_comb begin
    sync1_d = kbd_in;
    sync2_d = sync1_q;
    kbd_d   = sync2_q;
  end

  // Synchronizer and keyboard register flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 16'h0000;
      sync2_q <= 16'h0000;
      kbd_q   <= 16'h0000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      kbd_q   <= kbd_d;
    end
  end
`else
  // Keyboard code captured directly every cycle.
  always_comb begin
    kbd_d = kbd_in;
  end

  // Keyboard register flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbd_q <= 16'h0000;
    end else begin
      kbd_q <= kbd_d;
    end
  end
`endif

endmodule
